// File: rtl/dmem_port_ctrl_pkg.sv
// Shared types and constants for the data-memory port controller and its store buffer.
package dmem_port_ctrl_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic        half;
    } sb_entry_t;

    typedef logic [0:0] dmem_state_t;
    localparam dmem_state_t IDLE    = 1'b0;
    localparam dmem_state_t LD_WAIT = 1'b1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

// File: rtl/dmem_port_ctrl_store_buffer.sv
// Committed-store FIFO with a word-address match vector against the incoming load
// and the index of the youngest matching entry.
module dmem_port_ctrl_store_buffer
    import dmem_port_ctrl_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [31:0]                 push_addr,
    input  logic [31:0]                 push_data,
    input  logic                        push_half,
    input  logic                        pop,
    input  logic [29:0]                 cmp_word,
    output logic                        full,
    output logic                        empty,
    output sb_entry_t                   head_entry,
    output logic [SB_DEPTH-1:0]         match_vec,
    output logic [$clog2(SB_DEPTH)-1:0] youngest_idx,
    output sb_entry_t                   youngest_entry
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [CW-1:0]       count;
    logic [SB_DEPTH-1:0] vld;
    logic [PW-1:0]       scan_idx;

    logic [31:0] addr_q [SB_DEPTH];
    logic [31:0] data_q [SB_DEPTH];
    logic        half_q [SB_DEPTH];

    // Control state: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (push) begin
                vld[tail] <= 1'b1;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
            half_q[tail] <= push_half;
        end
    end

    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            match_vec[i] = vld[i] && (addr_q[i][31:2] == cmp_word);
        end
    end

    // Valid entries are contiguous from head, so the last hit in age order is the youngest.
    always_comb begin
        youngest_idx = '0;
        scan_idx     = head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            scan_idx = head + PW'(i);
            if (match_vec[scan_idx]) begin
                youngest_idx = scan_idx;
            end
        end
    end

    assign head_entry     = '{valid: vld[head], addr: addr_q[head],
                              data: data_q[head], half: half_q[head]};
    assign youngest_entry = '{valid: vld[youngest_idx], addr: addr_q[youngest_idx],
                              data: data_q[youngest_idx], half: half_q[youngest_idx]};
    assign full  = (count == CW'(SB_DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/dmem_port_ctrl.sv
// Single-port data-memory controller: store buffer drain, one outstanding load, load result return.
// Optional store-to-load forwarding of a buffered sw into an lw is enabled by DMEM_LD_FWD_EN.
module dmem_port_ctrl
    import dmem_port_ctrl_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int MEM_LAT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        st_half,
    output logic        st_full,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_func3,
    input  logic [6:0]  ld_pd,
    input  logic [4:0]  ld_rob,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        ld_done,
    output logic [6:0]  ld_done_pd,
    output logic [4:0]  ld_done_rob,
    output logic [31:0] ld_done_data
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    dmem_state_t   state;
    logic [CW-1:0] cnt;
    logic          ld_vld_p0;
    logic          ld_kill_p0;
    logic [31:0]   ld_addr_p0;
    logic [2:0]    ld_func3_p0;
    logic [6:0]    ld_pd_p0;
    logic [4:0]    ld_rob_p0;

    logic                sb_push, sb_pop, sb_full, sb_empty;
    sb_entry_t           sb_head, sb_young;
    logic [SB_DEPTH-1:0] sb_match;
    logic [PW-1:0]       sb_young_idx;

    logic        conflict_byp, conflict, fwd_ok;
    logic [31:0] fwd_data;
    logic        ld_accept, ld_fwd, ld_mem_accept, issue_ld, issue_st;

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            F3_LB:   r = 32'(b);
            F3_LH:   r = 32'(h);
            F3_LBU:  r = {24'b0, b};
            F3_LHU:  r = {16'b0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_be(input logic half, input logic a1);
        return half ? (a1 ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic [31:0] store_wdata(input logic half, input logic [31:0] d);
        return half ? {2{d[15:0]}} : d;
    endfunction

    assign sb_push = st_valid && !sb_full;
    assign st_full = sb_full;

    dmem_port_ctrl_store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
        .clk            (clk),
        .reset          (reset),
        .push           (sb_push),
        .push_addr      (st_addr),
        .push_data      (st_data),
        .push_half      (st_half),
        .pop            (sb_pop),
        .cmp_word       (ld_addr[31:2]),
        .full           (sb_full),
        .empty          (sb_empty),
        .head_entry     (sb_head),
        .match_vec      (sb_match),
        .youngest_idx   (sb_young_idx),
        .youngest_entry (sb_young)
    );

    // The entry being pushed this cycle is younger than anything already buffered.
    assign conflict_byp = sb_push && (st_addr[31:2] == ld_addr[31:2]);
    assign conflict     = conflict_byp || (|sb_match);

`ifdef DMEM_LD_FWD_EN
    always_comb begin
        if (conflict_byp) begin
            fwd_ok   = !st_half && (ld_func3 == F3_LW);
            fwd_data = st_data;
        end else begin
            fwd_ok   = !sb_young.half && (ld_func3 == F3_LW);
            fwd_data = sb_young.data;
        end
    end
`else
    assign fwd_ok   = 1'b0;
    assign fwd_data = '0;
`endif

    logic unused_sb;
    assign unused_sb = ^{sb_head.valid, sb_head.addr[0], sb_young_idx, sb_young};

    assign ld_ready = !reset && (state == IDLE) && !ld_vld_p0 && !flush && !sb_full
                      && (!conflict || fwd_ok);
    assign ld_accept     = ld_valid && ld_ready;
    assign ld_fwd        = ld_accept && conflict;
    assign ld_mem_accept = ld_accept && !conflict;

    // A registered load always wins the port over a store drain.
    assign issue_ld = (state == IDLE) && ld_vld_p0;
    assign issue_st = (state == IDLE) && !ld_vld_p0 && !sb_empty;
    assign sb_pop   = issue_st;

    always_comb begin
        mem_req   = issue_ld || issue_st;
        mem_we    = issue_st;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (issue_ld) begin
            mem_addr = {ld_addr_p0[31:2], 2'b00};
        end else if (issue_st) begin
            mem_addr  = {sb_head.addr[31:2], 2'b00};
            mem_wdata = store_wdata(sb_head.half, sb_head.data);
            mem_be    = store_be(sb_head.half, sb_head.addr[1]);
        end
    end

    // Stage p0: accepted load held until its memory wait completes.
    always_ff @(posedge clk) begin
        if (ld_mem_accept) begin
            ld_addr_p0  <= ld_addr;
            ld_func3_p0 <= ld_func3;
            ld_pd_p0    <= ld_pd;
            ld_rob_p0   <= ld_rob;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            ld_vld_p0    <= 1'b0;
            ld_kill_p0   <= 1'b0;
            ld_done      <= 1'b0;
            ld_done_pd   <= '0;
            ld_done_rob  <= '0;
            ld_done_data <= '0;
        end else begin
            ld_done <= 1'b0;
            if (ld_vld_p0 && flush) begin
                ld_kill_p0 <= 1'b1;
            end
            if (state == IDLE) begin
                if (ld_vld_p0) begin
                    state <= LD_WAIT;
                    cnt   <= CW'(MEM_LAT - 1);
                end
            end else if (cnt == '0) begin
                state     <= IDLE;
                ld_vld_p0 <= 1'b0;
                if (!ld_kill_p0 && !flush) begin
                    ld_done      <= 1'b1;
                    ld_done_pd   <= ld_pd_p0;
                    ld_done_rob  <= ld_rob_p0;
                    ld_done_data <= load_extract(ld_func3_p0, ld_addr_p0[1:0], mem_rdata);
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
            if (ld_mem_accept) begin
                ld_vld_p0  <= 1'b1;
                ld_kill_p0 <= 1'b0;
            end
            if (ld_fwd) begin
                ld_done      <= 1'b1;
                ld_done_pd   <= ld_pd;
                ld_done_rob  <= ld_rob;
                ld_done_data <= fwd_data;
            end
        end
    end

endmodule
